// File: rtl/top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// top : tick-driven PC sequencer with 3-level nested interrupts, hex display
// rev 1.0
// ---------------------------------------------------------------------------
module top #(
  parameter int ISR_LEN  = 8,
  parameter int SCAN_LSB = 14
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       Go,
  input  logic [2:0] Show,
  input  logic [1:0] Hz,
  input  logic       inter1,
  input  logic       inter2,
  input  logic       inter3,
  output logic       clk_N,
  output logic [7:0] SEG,
  output logic [7:0] AN,
  output logic [3:0] probe,
  output logic       inter_running1,
  output logic       inter_running2,
  output logic       inter_running3
);

  localparam logic [31:0] ISR_BYTES = 32'(4 * ISR_LEN);
  localparam logic [31:0] JMP_PC    = 32'h0000_003C;

  logic [23:0]         div_cnt;
  logic [SCAN_LSB+2:0] scan_cnt;
  logic [31:0]         pc;
  logic [31:0]         count_all;
  logic [31:0]         count_jmp;
  logic [31:0]         count_int;
  logic [1:0]          level;
  logic [31:0]         epc         [0:3];
  logic [1:0]          saved_level [0:3];
  logic [3:1]          pending;
  logic                clk_n_r;

  logic        tick;
  logic        active;
  logic        entry;
  logic [1:0]  hi_pend;
  logic [2:0]  clr_mask;
  logic [31:0] isr_end;
  logic [2:0]  scan_idx;
  logic [31:0] disp_val;
  logic [3:0]  nibble;

  always_comb begin
    unique case (Hz)
      2'd0:    tick = 1'b1;
      2'd1:    tick = &div_cnt[1:0];
      2'd2:    tick = &div_cnt[15:0];
      default: tick = &div_cnt[23:0];
    endcase
  end

  always_comb begin
    if (pending[3])      hi_pend = 2'd3;
    else if (pending[2]) hi_pend = 2'd2;
    else if (pending[1]) hi_pend = 2'd1;
    else                 hi_pend = 2'd0;
  end

  assign active  = tick & Go;
  assign entry   = active && (hi_pend > level);
  assign isr_end = {22'd0, level, 8'd0} + ISR_BYTES;

  always_comb begin
    clr_mask = 3'b000;
    if (entry) begin
      unique case (hi_pend)
        2'd1:    clr_mask = 3'b001;
        2'd2:    clr_mask = 3'b010;
        2'd3:    clr_mask = 3'b100;
        default: clr_mask = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt   <= '0;
      scan_cnt  <= '0;
      clk_n_r   <= 1'b0;
      pending   <= '0;
      pc        <= '0;
      level     <= '0;
      count_all <= '0;
      count_jmp <= '0;
      count_int <= '0;
      for (int i = 0; i < 4; i++) begin
        epc[i]         <= '0;
        saved_level[i] <= '0;
      end
    end else begin
      div_cnt  <= div_cnt + 24'd1;
      scan_cnt <= scan_cnt + 1'b1;
      if (tick) clk_n_r <= ~clk_n_r;
      // a fresh request on the same clk as its entry re-arms the bit
      pending <= (pending & ~clr_mask) | {inter3, inter2, inter1};
      if (active) begin
        if (entry) begin
          epc[hi_pend]         <= pc;
          saved_level[hi_pend] <= level;
          pc                   <= {22'd0, hi_pend, 8'd0};
          level                <= hi_pend;
          count_int            <= count_int + 32'd1;
        end else if ((level != 2'd0) && (pc == isr_end)) begin
          pc    <= epc[level];
          level <= saved_level[level];
        end else begin
          count_all <= count_all + 32'd1;
          if ((level == 2'd0) && (pc == JMP_PC)) begin
            pc        <= '0;
            count_jmp <= count_jmp + 32'd1;
          end else begin
            pc <= pc + 32'd4;
          end
        end
      end
    end
  end

  always_comb begin
    unique case (Show)
      3'd0:    disp_val = pc;
      3'd1:    disp_val = count_all;
      3'd2:    disp_val = count_jmp;
      3'd3:    disp_val = count_int;
      3'd4:    disp_val = {30'd0, level};
      default: disp_val = '0;
    endcase
  end

  assign scan_idx = scan_cnt[SCAN_LSB+2:SCAN_LSB];
  assign nibble   = disp_val[{scan_idx, 2'b00} +: 4];
  assign AN       = ~(8'd1 << scan_idx);

  always_comb begin
    SEG[7] = 1'b1;
    unique case (nibble)
      4'h0: SEG[6:0] = 7'h40;
      4'h1: SEG[6:0] = 7'h79;
      4'h2: SEG[6:0] = 7'h24;
      4'h3: SEG[6:0] = 7'h30;
      4'h4: SEG[6:0] = 7'h19;
      4'h5: SEG[6:0] = 7'h12;
      4'h6: SEG[6:0] = 7'h02;
      4'h7: SEG[6:0] = 7'h78;
      4'h8: SEG[6:0] = 7'h00;
      4'h9: SEG[6:0] = 7'h10;
      4'hA: SEG[6:0] = 7'h08;
      4'hB: SEG[6:0] = 7'h03;
      4'hC: SEG[6:0] = 7'h46;
      4'hD: SEG[6:0] = 7'h21;
      4'hE: SEG[6:0] = 7'h06;
      default: SEG[6:0] = 7'h0E;
    endcase
  end

  assign clk_N          = clk_n_r;
  assign probe          = {Go, level, clk_n_r};
  assign inter_running1 = (level == 2'd1);
  assign inter_running2 = (level == 2'd2);
  assign inter_running3 = (level == 2'd3);

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_top : directed self-checking bench for top
// rev 1.0
// ---------------------------------------------------------------------------
module tb_top;

  logic       clk = 1'b0;
  logic       clr;
  logic       Go;
  logic [2:0] Show;
  logic [1:0] Hz;
  logic       inter1, inter2, inter3;
  logic       clk_N;
  logic [7:0] SEG;
  logic [7:0] AN;
  logic [3:0] probe;
  logic       inter_running1, inter_running2, inter_running3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] hex_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  top #(.ISR_LEN(8), .SCAN_LSB(2)) dut (
    .clk(clk), .clr(clr), .Go(Go), .Show(Show), .Hz(Hz),
    .inter1(inter1), .inter2(inter2), .inter3(inter3),
    .clk_N(clk_N), .SEG(SEG), .AN(AN), .probe(probe),
    .inter_running1(inter_running1), .inter_running2(inter_running2),
    .inter_running3(inter_running3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // walks a full 8-digit scan and compares each lit digit to the value's nibble
  task automatic scan_check(input string tag, input logic [31:0] val);
    logic [7:0] an_n;
    int         idx;
    for (int s = 0; s < 32; s++) begin
      an_n = ~AN;
      check({tag, "_an_onehot"}, 32'($onehot(an_n)), 32'd1);
      idx = 0;
      for (int k = 0; k < 8; k++) if (an_n[k]) idx = k;
      check({tag, "_seg"}, {24'd0, SEG}, {24'd0, 1'b1, hex_tab[val[4*idx +: 4]]});
      step(1);
    end
  endtask

  initial begin
    int runs;
    clr = 1'b1; Go = 1'b0; Show = 3'd0; Hz = 2'd0;
    inter1 = 1'b0; inter2 = 1'b0; inter3 = 1'b0;

    // reset state
    step(2);
    check("rst_an",    {24'd0, AN},    32'hFE);
    check("rst_seg",   {24'd0, SEG},   32'hC0);
    check("rst_probe", {28'd0, probe}, 32'h0);
    check("rst_ir",    {29'd0, inter_running3, inter_running2, inter_running1}, 32'd0);
    Go = 1'b1;
    step(1);
    check("rst_probe_go", {28'd0, probe}, 32'h8);
    check("rst_pc",       dut.pc,         32'd0);

    // free run 20 ticks
    clr = 1'b0;
    step(20);
    check("run_all",   dut.count_all, 32'd20);
    check("run_pc",    dut.pc,        32'h10);
    check("run_jmp",   dut.count_jmp, 32'd1);
    check("run_level", {30'd0, dut.level}, 32'd0);
    check("run_probe", {28'd0, probe}, 32'h8);

    // single level-1 interrupt
    inter1 = 1'b1; step(1); inter1 = 1'b0;
    step(1);
    check("i1_pc",  dut.pc, 32'h100);
    check("i1_ir1", {31'd0, inter_running1}, 32'd1);
    runs = 1;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (inter_running1) runs++;
    end
    check("i1_runs",  runs,           32'd9);
    check("i1_retpc", dut.pc,         32'h14);
    check("i1_all",   dut.count_all,  32'd29);
    check("i1_int",   dut.count_int,  32'd1);

    // level 3 preempts level 1 at 0x10C
    inter1 = 1'b1; step(1); inter1 = 1'b0;
    step(3);
    inter3 = 1'b1; step(1); inter3 = 1'b0;
    check("nest_pc_pre", dut.pc, 32'h10C);
    step(1);
    check("nest_ir1", {31'd0, inter_running1}, 32'd0);
    check("nest_ir3", {31'd0, inter_running3}, 32'd1);
    check("nest_pc3", dut.pc, 32'h300);
    runs = 1;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (inter_running3) runs++;
    end
    check("nest_runs3",  runs,   32'd9);
    check("nest_resume", dut.pc, 32'h10C);
    check("nest_ir1_back", {31'd0, inter_running1}, 32'd1);
    step(6);
    check("nest_main_pc", dut.pc, 32'h18);
    check("nest_level",   {30'd0, dut.level}, 32'd0);
    check("nest_int",     dut.count_int, 32'd3);
    check("nest_all",     dut.count_all, 32'd46);

    // lower-level request held during level 3
    inter3 = 1'b1; step(1); inter3 = 1'b0;
    step(1);
    check("hold_probe_lvl", {29'd0, probe[3:1]}, 32'h7);
    inter1 = 1'b1; step(1); inter1 = 1'b0;
    step(7);
    check("hold_level3", {30'd0, dut.level}, 32'd3);
    check("hold_pc3",    dut.pc, 32'h320);
    check("hold_pend",   {29'd0, dut.pending}, 32'h1);
    step(1);
    check("hold_ret_pc", dut.pc, 32'h1C);
    check("hold_ret_lv", {30'd0, dut.level}, 32'd0);
    step(1);
    check("hold_enter1", dut.pc, 32'h100);
    check("hold_ir1",    {31'd0, inter_running1}, 32'd1);
    step(9);
    check("hold_done_pc", dut.pc, 32'h1C);
    check("hold_int",     dut.count_int, 32'd5);
    check("hold_all",     dut.count_all, 32'd63);

    // Go=0 freezes the core but keeps requests
    Go = 1'b0;
    inter2 = 1'b1; step(1); inter2 = 1'b0;
    step(9);
    check("frz_pc",   dut.pc,        32'h1C);
    check("frz_all",  dut.count_all, 32'd63);
    check("frz_pend", {29'd0, dut.pending}, 32'h2);
    Go = 1'b1;
    step(1);
    check("frz_enter2", dut.pc, 32'h200);
    check("frz_ir2",    {31'd0, inter_running2}, 32'd1);
    step(9);
    check("frz_ret_pc", dut.pc,        32'h1C);
    check("frz_all2",   dut.count_all, 32'd71);
    check("frz_int",    dut.count_int, 32'd6);

    // request coincident with clr is discarded
    inter3 = 1'b1; clr = 1'b1; step(1); inter3 = 1'b0;
    check("clr_pend", {29'd0, dut.pending}, 32'h0);
    check("clr_pc",   dut.pc,        32'd0);
    check("clr_all",  dut.count_all, 32'd0);
    check("clr_an",   {24'd0, AN},   32'hFE);
    clr = 1'b0;
    step(18);
    check("disp_all", dut.count_all, 32'h12);
    Go = 1'b0;
    Show = 3'd1; scan_check("show_all", 32'h12);
    Show = 3'd2; scan_check("show_jmp", 32'h1);
    Show = 3'd0; scan_check("show_pc",  32'h8);
    Show = 3'd3; scan_check("show_int", 32'h0);
    Show = 3'd6; scan_check("show_zero", 32'h0);

    // Hz=1 divides ticks by 4
    clr = 1'b1; step(1);
    clr = 1'b0; Hz = 2'd1; Go = 1'b1;
    step(8);
    check("hz1_all8",  dut.count_all, 32'd2);
    check("hz1_clkn8", {31'd0, clk_N}, 32'd0);
    step(4);
    check("hz1_all12", dut.count_all, 32'd3);
    check("hz1_probe", {28'd0, probe}, 32'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
